// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch (IF) and load/store (DM)
//   Grants one access at a time, strobes the fixed-latency memory and returns data with a
//   one-cycle ack; the stall outputs hold the pipeline while a request is outstanding.
//   Optional build macro ARB_RR_EN: round-robin between IF and DM when both request.
//   Default build: DM has priority, with at most MAX_DATA_RUN back-to-back DM grants while IF waits.
// Ports:
//   i_clk, i_rst_n                  clock, asynchronous active-low reset
//   i_if_req, i_if_addr             fetch request and address
//   o_if_rdata, o_if_ack            fetched word and its one-cycle completion pulse
//   i_dm_req, i_dm_we               data request and write enable (1 = store)
//   i_dm_addr, i_dm_wdata           data address and store data
//   o_dm_rdata, o_dm_ack            load word and its one-cycle completion pulse
//   o_mem_en, o_mem_we              one-cycle memory strobe and write enable
//   o_mem_addr, o_mem_wdata         memory address and write data, held for the whole access
//   i_mem_rdata                     memory read data, valid MEM_LAT cycles after o_mem_en
//   o_stall_if, o_stall_dm          pipeline holds while the matching request is not acked
module mem_port_arbiter #(
  parameter int AW           = 16,
  parameter int DW           = 16,
  parameter int MEM_LAT      = 2,
  parameter int MAX_DATA_RUN = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_if_req,
  input  logic [AW-1:0] i_if_addr,
  output logic [DW-1:0] o_if_rdata,
  output logic          o_if_ack,
  input  logic          i_dm_req,
  input  logic          i_dm_we,
  input  logic [AW-1:0] i_dm_addr,
  input  logic [DW-1:0] i_dm_wdata,
  output logic [DW-1:0] o_dm_rdata,
  output logic          o_dm_ack,
  output logic          o_mem_en,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata,
  output logic          o_stall_if,
  output logic          o_stall_dm
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t        r_state, w_next;
  logic [3:0]    r_cnt;
  logic          r_win_dm, r_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata, r_if_rdata, r_dm_rdata;
  logic          w_req, w_grant, w_grant_dm, w_capture;
  assign w_req     = i_if_req | i_dm_req;
  assign w_grant   = (r_state == IDLE) & w_req;
  assign w_capture = (r_state == WAIT) & (r_cnt == 4'd0);
`ifdef ARB_RR_EN
  logic r_last_dm;
  assign w_grant_dm = i_dm_req & (~i_if_req | ~r_last_dm);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_last_dm <= 1'b0;
    else if (w_grant) r_last_dm <= w_grant_dm;
`else
  logic [3:0] r_run;
  assign w_grant_dm = i_dm_req & (~i_if_req | (r_run != 4'(MAX_DATA_RUN)));
  // counts DM grants that overtook a waiting IF; an IF grant or an uncontested DM grant clears it
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_run <= 4'd0;
    else if (w_grant)
      r_run <= (w_grant_dm & i_if_req) ? ((r_run == 4'(MAX_DATA_RUN)) ? r_run : r_run + 4'd1) : 4'd0;
`endif
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb
    w_next = (r_state == IDLE) ? (w_req ? WAIT : IDLE) :
             (r_state == WAIT) ? (r_cnt == 4'd0 ? RESP : WAIT) : IDLE;
  // WAIT lasts MEM_LAT+1 cycles: the strobe cycle plus the memory latency, so the
  // capture edge lands at the end of the first cycle where read data is valid
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_cnt       <= 4'd0;
      r_win_dm    <= 1'b0;
      r_we        <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
    end else begin
      if (w_grant) begin
        r_cnt      <= 4'(MEM_LAT);
        r_win_dm   <= w_grant_dm;
        r_we       <= w_grant_dm & i_dm_we;
        r_mem_addr <= w_grant_dm ? i_dm_addr : i_if_addr;
        if (w_grant_dm) r_mem_wdata <= i_dm_wdata;
      end
      if (r_state == WAIT && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
      if (w_capture && !r_win_dm) r_if_rdata <= i_mem_rdata;
      if (w_capture && r_win_dm && !r_we) r_dm_rdata <= i_mem_rdata;
    end
  // the counter still holds its load value only in the first WAIT cycle, which is the strobe cycle
  always_comb begin
    o_mem_en   = (r_state == WAIT) & (r_cnt == 4'(MEM_LAT));
    o_mem_we   = o_mem_en & r_we;
    o_if_ack   = (r_state == RESP) & ~r_win_dm;
    o_dm_ack   = (r_state == RESP) & r_win_dm;
    o_stall_if = i_if_req & ~o_if_ack;
    o_stall_dm = i_dm_req & ~o_dm_ack;
  end
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_if_rdata  = r_if_rdata;
  assign o_dm_rdata  = r_dm_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench with a timeline model of the arbiter and a fixed-latency memory
module tb_mem_port_arbiter;
  localparam int LAT = 2;
  localparam int MAXR = 4;
  localparam logic [15:0] IFA = 16'h1000;
  localparam logic [15:0] DMA = 16'h2000;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [15:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, mem_rdata = 16'hEEEE;
  logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic if_ack, dm_ack, mem_en, mem_we, stall_if, stall_dm;
  logic dm_req1 = 1'b0;
  logic [15:0] mem_rdata1 = 16'hEEEE;
  logic [15:0] if_rdata1, dm_rdata1, mem_addr1, mem_wdata1;
  logic if_ack1, dm_ack1, mem_en1, mem_we1, stall_if1, stall_dm1;
  int n_cmp = 0, n_err = 0, cyc = 0;
  logic [15:0] mem [logic [15:0]];
  int rd_due = -1, rd_due1 = -1;
  logic [15:0] rd_addr = '0;
  int t_en = -1, t_ack = -1, t_free = 0, run = 0;
  logic last_dm = 1'b0, g_dm = 1'b0, g_we = 1'b0;
  logic [15:0] g_addr = '0, g_wdata = '0, exp_if_rdata = '0, exp_dm_rdata = '0;
  logic mlog[$], dlog[$];
  int last_en_cyc = -1, n_dm_ack = 0;

  mem_port_arbiter #(.AW(16), .DW(16), .MEM_LAT(LAT), .MAX_DATA_RUN(MAXR)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_if_req(if_req), .i_if_addr(if_addr),
    .o_if_rdata(if_rdata), .o_if_ack(if_ack), .i_dm_req(dm_req), .i_dm_we(dm_we),
    .i_dm_addr(dm_addr), .i_dm_wdata(dm_wdata), .o_dm_rdata(dm_rdata), .o_dm_ack(dm_ack),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .o_stall_if(stall_if), .o_stall_dm(stall_dm));

  mem_port_arbiter #(.AW(16), .DW(16), .MEM_LAT(1), .MAX_DATA_RUN(MAXR)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_if_req(1'b0), .i_if_addr(16'h0000),
    .o_if_rdata(if_rdata1), .o_if_ack(if_ack1), .i_dm_req(dm_req1), .i_dm_we(1'b0),
    .i_dm_addr(16'h0003), .i_dm_wdata(16'h0000), .o_dm_rdata(dm_rdata1), .o_dm_ack(dm_ack1),
    .o_mem_en(mem_en1), .o_mem_we(mem_we1), .o_mem_addr(mem_addr1), .o_mem_wdata(mem_wdata1),
    .i_mem_rdata(mem_rdata1), .o_stall_if(stall_if1), .o_stall_dm(stall_dm1));

  always #5 clk = ~clk;

  function automatic logic [15:0] rd_val(input logic [15:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 16'hA5A5);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  // memory and model both advance on the rising edge; the model works on absolute cycle
  // numbers: a grant decided at the end of cycle p strobes in p+1 and acks in p+LAT+2
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] = mem_wdata;
      rd_addr = mem_addr;
      rd_due = cyc + LAT;
    end
    if (mem_en1) rd_due1 = cyc + 1;
    cyc = cyc + 1;
    mem_rdata <= (cyc == rd_due) ? rd_val(rd_addr) : 16'hEEEE;
    mem_rdata1 <= (cyc == rd_due1) ? 16'h7777 : 16'hEEEE;
    if (!rst_n) begin
      t_en = -1; t_ack = -1; t_free = cyc; run = 0; last_dm = 1'b0;
      g_dm = 1'b0; g_we = 1'b0; g_addr = '0; exp_if_rdata = '0; exp_dm_rdata = '0;
    end else begin
      if (cyc - 1 >= t_free && (if_req || dm_req)) begin
`ifdef ARB_RR_EN
        g_dm = dm_req && (!if_req || !last_dm);
`else
        g_dm = dm_req && (!if_req || run < MAXR);
        run = (g_dm && if_req) ? ((run < MAXR) ? run + 1 : run) : 0;
`endif
        last_dm = g_dm;
        g_we = g_dm && dm_we;
        g_addr = g_dm ? dm_addr : if_addr;
        g_wdata = dm_wdata;
        t_en = cyc;
        t_ack = cyc + LAT + 1;
        t_free = t_ack + 1;
        mlog.push_back(g_dm);
      end
      if (cyc == t_ack) begin
        if (!g_dm) exp_if_rdata = rd_val(g_addr);
        else if (!g_we) exp_dm_rdata = rd_val(g_addr);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_if_ack", 32'(if_ack), 32'd0);
      chk("rst_dm_ack", 32'(dm_ack), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      chk("rst_if_rdata", 32'(if_rdata), 32'd0);
      chk("rst_dm_rdata", 32'(dm_rdata), 32'd0);
    end else begin
      chk("mem_en", 32'(mem_en), 32'(cyc == t_en));
      chk("mem_we", 32'(mem_we), 32'(cyc == t_en && g_we));
      chk("if_ack", 32'(if_ack), 32'(cyc == t_ack && !g_dm));
      chk("dm_ack", 32'(dm_ack), 32'(cyc == t_ack && g_dm));
      chk("stall_if", 32'(stall_if), 32'(if_req && !(cyc == t_ack && !g_dm)));
      chk("stall_dm", 32'(stall_dm), 32'(dm_req && !(cyc == t_ack && g_dm)));
      chk("dm_rdata", 32'(dm_rdata), 32'(exp_dm_rdata));
      if (t_en >= 0 && cyc >= t_en && cyc <= t_ack) chk("mem_addr", 32'(mem_addr), 32'(g_addr));
      if (cyc == t_en && g_we) chk("mem_wdata", 32'(mem_wdata), 32'(g_wdata));
      if (cyc == t_ack && !g_dm) chk("if_rdata", 32'(if_rdata), 32'(exp_if_rdata));
    end
    if (mem_en) begin
      last_en_cyc = cyc;
      dlog.push_back(mem_addr == DMA);
    end
    if (dm_ack) n_dm_ack++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_ack(input bit dm, output int c, output logic [15:0] r);
    c = -1;
    r = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dm ? dm_ack : if_ack) begin
        c = cyc;
        r = dm ? dm_rdata : if_rdata;
        break;
      end
    end
    if (c < 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL ack_timeout: got no ack, expected one within 40 cycles");
    end
    @(posedge clk);
    #2;
  endtask

  task automatic do_if(input logic [15:0] a, output logic [15:0] r, output int c0, output int ca);
    c0 = cyc;
    if_addr = a;
    if_req = 1'b1;
    wait_ack(1'b0, ca, r);
    if_req = 1'b0;
  endtask

  task automatic do_dm(input logic we, input logic [15:0] a, input logic [15:0] d,
                       output logic [15:0] r, output int ca);
    dm_we = we;
    dm_addr = a;
    dm_wdata = d;
    dm_req = 1'b1;
    wait_ack(1'b1, ca, r);
    dm_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion within 200000 time units");
    $fatal(1);
  end

  initial begin
    logic [15:0] r;
    int c0, ca, n0, n_en, n_ack, ack_c;
    logic exp3 [10];
`ifdef ARB_RR_EN
    exp3 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp3 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`endif
    mem[16'h0010] = 16'hB123;
    mem[16'h0030] = 16'h1234;
    mem[16'h0040] = 16'h0F0F;
    mem[16'h0050] = 16'hC0DE;
    #1 rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    // IF-only fetch: strobe one cycle after request, ack three cycles after strobe
    do_if(16'h0010, r, c0, ca);
    chk("t1_en_cycle", 32'(last_en_cyc - c0), 32'd1);
    chk("t1_ack_cycle", 32'(ca - c0), 32'd4);
    chk("t1_rdata", 32'(r), 32'hB123);
    chk("t1_model_ack", 32'(t_ack - c0), 32'd4);
    tick(2);
    // DM load, then store (load data must stay), then load back the stored word
    do_dm(1'b0, 16'h0030, 16'h0000, r, ca);
    chk("t2_load", 32'(r), 32'h1234);
    do_dm(1'b1, 16'h0020, 16'h5A5A, r, ca);
    chk("t2_ack_after_en", 32'(ca - last_en_cyc), 32'd3);
    chk("t2_rdata_held", 32'(r), 32'h1234);
    chk("t2_mem_written", 32'(mem[16'h0020]), 32'h5A5A);
    do_dm(1'b0, 16'h0020, 16'h0000, r, ca);
    chk("t2_readback", 32'(r), 32'h5A5A);
    // request address changes while the access is in flight: latched address wins
    if_addr = 16'h0050;
    if_req = 1'b1;
    tick(1);
    if_addr = 16'h0060;
    wait_ack(1'b0, ca, r);
    if_req = 1'b0;
    chk("t7_latched", 32'(r), 32'hC0DE);
    tick(2);
    // both requesters held high: grant order
    mlog.delete();
    dlog.delete();
    if_addr = IFA;
    dm_addr = DMA;
    dm_we = 1'b0;
    if_req = 1'b1;
    dm_req = 1'b1;
    for (int i = 0; i < 300 && dlog.size() < 10; i++) @(negedge clk);
    if (dlog.size() < 10) begin
      n_cmp++;
      n_err++;
      $display("FAIL t3_grant_timeout: got %0d grants, expected 10", dlog.size());
    end
    tick(1);
    if_req = 1'b0;
    dm_req = 1'b0;
    tick(8);
    for (int i = 0; i < 10; i++) begin
      if (i < mlog.size()) chk($sformatf("t3_model_grant_%0d", i), 32'(mlog[i]), 32'(exp3[i]));
      if (i < dlog.size()) chk($sformatf("t3_dut_grant_%0d", i), 32'(dlog[i]), 32'(exp3[i]));
    end
    // reset during WAIT of a DM read
    dm_addr = 16'h0070;
    dm_we = 1'b0;
    dm_req = 1'b1;
    for (int i = 0; i < 20 && !mem_en; i++) @(negedge clk);
    tick(1);
    n0 = n_dm_ack;
    rst_n = 1'b0;
    dm_req = 1'b0;
    #1;
    chk("t5_mem_en", 32'(mem_en), 32'd0);
    chk("t5_dm_ack", 32'(dm_ack), 32'd0);
    chk("t5_mem_addr", 32'(mem_addr), 32'd0);
    chk("t5_dm_rdata", 32'(dm_rdata), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(4);
    chk("t5_no_ack", 32'(n_dm_ack - n0), 32'd0);
    do_if(16'h0040, r, c0, ca);
    chk("t5_fresh_if", 32'(r), 32'h0F0F);
    chk("t5_fresh_ack_cycle", 32'(ca - c0), 32'd4);
    tick(2);
    // MEM_LAT=1 instance: single-cycle DM pulse
    dm_req1 = 1'b1;
    c0 = cyc;
    tick(1);
    dm_req1 = 1'b0;
    n_en = 0;
    n_ack = 0;
    ack_c = -1;
    r = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (mem_en1) n_en++;
      if (dm_ack1) begin
        n_ack++;
        ack_c = cyc;
        r = dm_rdata1;
      end
    end
    chk("t6_en_count", 32'(n_en), 32'd1);
    chk("t6_ack_count", 32'(n_ack), 32'd1);
    chk("t6_ack_cycle", 32'(ack_c - c0), 32'd3);
    chk("t6_rdata", 32'(r), 32'h7777);
    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
